c2c_link_ctrl: RTL and testbench

C2C_LINK_CTRL -- requirements
Module: c2c_link_ctrl

---
 rtl/c2c_pkg.sv | 36 +++
 rtl/rr_arb2.sv | 31 +++
 rtl/c2c_link_ctrl.sv | 133 +++++++++++++
 tb/tb_c2c_link_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/c2c_pkg.sv
// c2c_pkg: shared definitions for the chip-to-chip link controller.
//   - linkState_t : bring-up FSM state encoding
//   - header bit positions, payload width and the idle word on the ring
//   - txWord_t    : ring word layout {valid, src_id, payload}
package c2c_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RST  = 3'd1,
        ST_CAL  = 3'd2,
        ST_SYNC = 3'd3,
        ST_UP   = 3'd4
    } linkState_t;

    localparam int VALID_BIT = 63;
    localparam int SRC_BIT   = 62;
    localparam int PAYLOAD_W = 62;
    localparam int WORD_W    = 64;

    localparam logic [WORD_W-1:0] IDLE_WORD = 64'h0;

    typedef struct packed {
        logic                 valid;    // bit VALID_BIT
        logic                 src;      // bit SRC_BIT
        logic [PAYLOAD_W-1:0] payload;
    } txWord_t;

    function automatic txWord_t mkWord(input logic src, input logic [PAYLOAD_W-1:0] data);
        txWord_t w;
        w.valid   = 1'b1;
        w.src     = src;
        w.payload = data;
        return w;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// rr_arb2: two-way round-robin arbiter.
//   CLK, Reset : clock, synchronous active-high reset
//   clear      : re-arm the pointer so requester 0 wins next
//   advance    : a grant was consumed this cycle; move the pointer
//   reqValid   : per-requester valid
//   grant      : one-hot (or zero) grant, combinational
module rr_arb2 (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       clear,
    input  logic       advance,
    input  logic [1:0] reqValid,
    output logic [1:0] grant
);

    // High when requester 1 took the last grant, so requester 0 is favoured.
    logic lastWas1;

    always_comb begin
        grant[0] = reqValid[0] & (~reqValid[1] | lastWas1);
        grant[1] = reqValid[1] & ~grant[0];
    end

    always_ff @(posedge CLK) begin
        if (Reset || clear)
            lastWas1 <= 1'b1;
        else if (advance)
            lastWas1 <= grant[1];
    end

endmodule

// File: rtl/c2c_link_ctrl.sv
// c2c_link_ctrl: bring-up FSM and two-requester transmit mux for a ring link.
//   CLK, Reset            : clock, synchronous active-high reset
//   partner_ready         : remote board powered and configured
//   link_lock / peer_lock : local / remote ring calibration complete
//   link_reset, lock_go   : ring Reset and lock_in controls
//   reqN_valid/data/ready : requester handshakes (ready is combinational)
//   tx_word               : ring din, {valid, src_id, payload}, one cycle after accept
//   link_up               : high in UP
//   retrain_cnt           : failed/dropped attempts, saturating
module c2c_link_ctrl
    import c2c_pkg::*;
#(
    parameter int RESET_CYCLES = 16,
    parameter int LOCK_TIMEOUT = 4096
) (
    input  logic                 CLK,
    input  logic                 Reset,
    input  logic                 partner_ready,
    input  logic                 link_lock,
    input  logic                 peer_lock,
    output logic                 link_reset,
    output logic                 lock_go,
    input  logic                 req0_valid,
    input  logic [PAYLOAD_W-1:0] req0_data,
    output logic                 req0_ready,
    input  logic                 req1_valid,
    input  logic [PAYLOAD_W-1:0] req1_data,
    output logic                 req1_ready,
    output logic [WORD_W-1:0]    tx_word,
    output logic                 link_up,
    output logic [7:0]           retrain_cnt
);

    localparam int MAX_CNT = (LOCK_TIMEOUT > RESET_CYCLES) ? LOCK_TIMEOUT : RESET_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CNT + 1);
    localparam logic [CNT_W-1:0] RST_LAST = CNT_W'(RESET_CYCLES - 1);
    localparam logic [CNT_W-1:0] CAL_LAST = CNT_W'(LOCK_TIMEOUT - 1);

    linkState_t       state, nextState;
    logic [CNT_W-1:0] cnt;
    logic             bumpRetrain;
    logic             upHealthy;
    logic [1:0]       grant, accept;
    txWord_t          txQ;

    // ---------------- next-state ----------------
    always_comb begin
        nextState   = state;
        bumpRetrain = 1'b0;
        case (state)
            ST_IDLE: if (partner_ready) nextState = ST_RST;
            ST_RST: begin
                if (!partner_ready)       nextState = ST_IDLE;
                else if (cnt == RST_LAST) nextState = ST_CAL;
            end
            ST_CAL: begin
                if (!partner_ready)       nextState = ST_IDLE;
                else if (link_lock)       nextState = ST_SYNC;
                else if (cnt == CAL_LAST) begin
                    nextState   = ST_RST;
                    bumpRetrain = 1'b1;
                end
            end
            ST_SYNC: begin
                if (!partner_ready)       nextState = ST_IDLE;
                else if (!link_lock) begin
                    nextState   = ST_RST;
                    bumpRetrain = 1'b1;
                end
                else if (peer_lock)       nextState = ST_UP;
            end
            ST_UP: begin
                // Partner loss here is a dropped link, so it retrains rather than idling.
                if (!partner_ready || !link_lock || !peer_lock) begin
                    nextState   = ST_RST;
                    bumpRetrain = 1'b1;
                end
            end
            default: nextState = ST_IDLE;
        endcase
    end

    // ---------------- arbitration / handshake ----------------
    // Accept only while UP and staying UP, so no payload is taken on the
    // cycle the link is being torn down.
    assign upHealthy = (state == ST_UP) & partner_ready & link_lock & peer_lock;

    rr_arb2 uArb (
        .CLK      (CLK),
        .Reset    (Reset),
        .clear    (state != ST_UP),
        .advance  (|accept),
        .reqValid ({req1_valid, req0_valid}),
        .grant    (grant)
    );

    assign accept     = grant & {2{upHealthy}};
    assign req0_ready = accept[0];
    assign req1_ready = accept[1];

    // ---------------- state, counters, registered outputs ----------------
    always_ff @(posedge CLK) begin
        if (Reset) begin
            state       <= ST_IDLE;
            cnt         <= '0;
            retrain_cnt <= 8'd0;
            lock_go     <= 1'b0;
            txQ         <= txWord_t'(IDLE_WORD);
        end else begin
            state <= nextState;
            // Restart on every state change; hold at all-ones instead of wrapping.
            if (nextState != state)
                cnt <= '0;
            else if (cnt != {CNT_W{1'b1}})
                cnt <= cnt + CNT_W'(1);
            if (bumpRetrain && retrain_cnt != 8'hFF)
                retrain_cnt <= retrain_cnt + 8'd1;
            // Registered from nextState so it rises with link_up.
            lock_go <= (nextState == ST_UP);
            if (accept[0])
                txQ <= mkWord(1'b0, req0_data);
            else if (accept[1])
                txQ <= mkWord(1'b1, req1_data);
            else
                txQ <= txWord_t'(IDLE_WORD);
        end
    end

    assign tx_word    = txQ;
    assign link_up    = (state == ST_UP);
    assign link_reset = (state == ST_IDLE) || (state == ST_RST);

endmodule

// File: tb/tb_c2c_link_ctrl.sv
module tb_c2c_link_ctrl;

    localparam int RC = 16;
    localparam int LT = 128;

    logic        CLK = 1'b0;
    logic        Reset = 1'b1;
    logic        partner_ready = 1'b0, link_lock = 1'b0, peer_lock = 1'b0;
    logic        link_reset, lock_go, link_up;
    logic        req0_valid = 1'b0, req1_valid = 1'b0;
    logic [61:0] req0_data = '0, req1_data = '0;
    logic        req0_ready, req1_ready;
    logic [63:0] tx_word;
    logic [7:0]  retrain_cnt;

    c2c_link_ctrl #(.RESET_CYCLES(RC), .LOCK_TIMEOUT(LT)) dut (
        .CLK(CLK), .Reset(Reset),
        .partner_ready(partner_ready), .link_lock(link_lock), .peer_lock(peer_lock),
        .link_reset(link_reset), .lock_go(lock_go),
        .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
        .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
        .tx_word(tx_word), .link_up(link_up), .retrain_cnt(retrain_cnt)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        v0, v1;
        logic [61:0] d0, d1;
        logic        r0, r1;
    } vec_t;

    vec_t        tbl[12];
    logic [63:0] sbq[$];
    int          checks = 0, failures = 0, cyc = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge CLK);
        cyc++;
        #1;
    endtask

    // Advance one cycle and compare tx_word against the scoreboard head.
    task automatic stepTx(input string nm);
        logic [63:0] exp;
        step();
        exp = (sbq.size() > 0) ? sbq.pop_front() : 64'h0;
        chk(nm, tx_word, exp);
    endtask

    task automatic waitLR(input logic lvl, input int bound, input string nm);
        int n = 0;
        while (link_reset !== lvl && n < bound) begin step(); n++; end
        chk(nm, link_reset, lvl);
    endtask

    task automatic waitUp(input int bound, input string nm);
        int n = 0;
        while (link_up !== 1'b1 && n < bound) begin step(); n++; end
        chk(nm, link_up, 1'b1);
    endtask

    task automatic measureLR(input logic lvl, output int n);
        n = 0;
        while (link_reset === lvl && n < 5000) begin step(); n++; end
    endtask

    task automatic pulseReset();
        Reset = 1'b1; step(); step(); Reset = 1'b0;
    endtask

    initial begin
        int n;
        tbl[0]  = '{1'b1, 1'b1, 62'hA, 62'hB, 1'b1, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 62'hA, 62'hB, 1'b0, 1'b1};
        tbl[2]  = '{1'b1, 1'b1, 62'hA, 62'hB, 1'b1, 1'b0};
        tbl[3]  = '{1'b1, 1'b1, 62'hA, 62'hB, 1'b0, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 62'h5, 62'h0, 1'b1, 1'b0};
        tbl[5]  = '{1'b1, 1'b0, 62'h6, 62'h0, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 62'h7, 62'h8, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 62'h0, 62'h9, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 62'h1, 62'h2, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 62'h1, 62'h2, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b1, 62'h0, 62'h3FFF_FFFF_FFFF_FFFF, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b1, 62'h0, 62'h0, 1'b1, 1'b0};

        // ---- reset values ----
        step(); step();
        chk("rst_link_reset", link_reset, 1'b1);
        chk("rst_lock_go", lock_go, 1'b0);
        chk("rst_link_up", link_up, 1'b0);
        chk("rst_tx_word", tx_word, 64'h0);
        chk("rst_retrain", retrain_cnt, 8'd0);
        chk("rst_ready", {req1_ready, req0_ready}, 2'b00);

        // ---- Scenario A: timed bring-up ----
        Reset = 1'b0;
        cyc = 0;
        while (cyc < 10) step();
        partner_ready = 1'b1;
        while (cyc < 26) step();
        chk("A_link_reset_c26", link_reset, 1'b1);
        step();
        chk("A_link_reset_c27", link_reset, 1'b0);
        while (cyc < 100) step();
        link_lock = 1'b1;
        while (cyc < 120) step();
        chk("A_link_up_c120", link_up, 1'b0);
        peer_lock = 1'b1;
        step();
        chk("A_link_up_c121", link_up, 1'b1);
        chk("A_lock_go_c121", lock_go, 1'b1);
        chk("A_retrain", retrain_cnt, 8'd0);

        // ---- Scenario C + arbitration table ----
        foreach (tbl[i]) begin
            req0_valid = tbl[i].v0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_data = tbl[i].d1;
            #1;
            chk($sformatf("tbl%0d_ready0", i), req0_ready, tbl[i].r0);
            chk($sformatf("tbl%0d_ready1", i), req1_ready, tbl[i].r1);
            if (tbl[i].r0)      sbq.push_back({1'b1, 1'b0, tbl[i].d0});
            else if (tbl[i].r1) sbq.push_back({1'b1, 1'b1, tbl[i].d1});
            stepTx($sformatf("tbl%0d_tx_word", i));
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        stepTx("tbl_idle_tx_word");

        // ---- Scenario D: link_lock drop with req0 pending ----
        req0_valid = 1'b1; req0_data = 62'h55; link_lock = 1'b0;
        #1;
        chk("D_ready0", req0_ready, 1'b0);
        step();
        chk("D_tx_word", tx_word, 64'h0);
        chk("D_link_up", link_up, 1'b0);
        chk("D_lock_go", lock_go, 1'b0);
        chk("D_link_reset", link_reset, 1'b1);
        chk("D_retrain", retrain_cnt, 8'd1);
        req0_valid = 1'b0;
        link_lock = 1'b1;
        waitUp(60, "D_reentry_up");
        // Pointer re-armed on entry: requester 0 first even though it won last.
        req0_valid = 1'b1; req0_data = 62'h1; req1_valid = 1'b1; req1_data = 62'h2;
        #1;
        chk("D_reentry_rr", {req1_ready, req0_ready}, 2'b01);
        sbq.push_back({2'b10, 62'h1});
        stepTx("D_reentry_tx_word");

        // ---- Scenario E1: Reset during UP with traffic ----
        Reset = 1'b1;
        step();
        chk("E_link_up", link_up, 1'b0);
        chk("E_lock_go", lock_go, 1'b0);
        chk("E_ready", {req1_ready, req0_ready}, 2'b00);
        chk("E_tx_word", tx_word, 64'h0);
        chk("E_retrain", retrain_cnt, 8'd0);
        chk("E_link_reset", link_reset, 1'b1);
        sbq.delete();
        Reset = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

        // ---- Scenario E2: partner_ready drop in CAL ----
        link_lock = 1'b0; peer_lock = 1'b0;
        waitLR(1'b0, 40, "E2_enter_cal");
        waitLR(1'b1, LT + 10, "E2_timeout");
        chk("E2_retrain_1", retrain_cnt, 8'd1);
        waitLR(1'b0, 40, "E2_reenter_cal");
        partner_ready = 1'b0;
        step();
        chk("E2_link_reset", link_reset, 1'b1);
        chk("E2_retrain_kept", retrain_cnt, 8'd1);
        repeat (30) step();
        chk("E2_idle_hold", link_reset, 1'b1);
        chk("E2_retrain_hold", retrain_cnt, 8'd1);

        // ---- Scenario B: two timeouts, 16-cycle reset pulses ----
        pulseReset();
        partner_ready = 1'b1;
        waitLR(1'b0, 40, "B_enter_cal");
        for (int i = 0; i < 2; i++) begin
            measureLR(1'b0, n);
            chk($sformatf("B_cal_len%0d", i), n, LT);
            chk($sformatf("B_retrain%0d", i), retrain_cnt, i + 1);
            measureLR(1'b1, n);
            chk($sformatf("B_rst_len%0d", i), n, RC);
        end

        // ---- Scenario F: saturation after 300 timeouts ----
        pulseReset();
        partner_ready = 1'b1;
        repeat (RC + 1 + 300 * (LT + RC) + 50) step();
        chk("F_retrain_sat", retrain_cnt, 8'd255);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
